parallel_latch_reader: RTL and testbench

//  Read-side drain for a bank of WAY independent WIRE-bit latch groups (per-way latch enables, flat Q bus).

---
 rtl/parallel_latch_reader_pkg.sv | 15 +
 rtl/parallel_latch_reader_rr_pick.sv | 32 +++
 rtl/parallel_latch_reader.sv | 112 +++++++++++
 tb/tb_parallel_latch_reader.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/parallel_latch_reader_pkg.sv
// Shared definitions for the parallel latch reader: output-register state
// encoding and the way-index width helper used by the top and the arbiter.
package parallel_latch_reader_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } outState_e;

  // A single way still needs a one-bit index so that ports never collapse to zero width.
  function automatic int idxWidth(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/parallel_latch_reader_rr_pick.sv
// Rotating-priority encoder: grants the first requesting way found when
// scanning from ptr_i upwards and wrapping modulo WAY.
module rr_pick
  import parallel_latch_reader_pkg::*;
#(
  parameter int WAY = 3
) (
  input  logic [WAY-1:0]              req_i,
  input  logic [idxWidth(WAY)-1:0]    ptr_i,
  output logic [idxWidth(WAY)-1:0]    gnt_idx_o,
  output logic                        gnt_any_o
);

  localparam int IDXW = idxWidth(WAY);

  function automatic logic [IDXW-1:0] wrapIdx(input int v);
    return IDXW'(v % WAY);
  endfunction

  // Scan from the farthest offset back to ptr_i so the closest requester from the pointer wins.
  always_comb begin
    gnt_idx_o = '0;
    gnt_any_o = 1'b0;
    for (int k = WAY - 1; k >= 0; k--) begin
      if (req_i[wrapIdx(int'(ptr_i) + k)]) begin
        gnt_idx_o = wrapIdx(int'(ptr_i) + k);
        gnt_any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/parallel_latch_reader.sv
// Read-side drain for a bank of latch groups: notices each way closing its
// latch, marks it pending and streams the captured word out one way per
// transfer in round-robin order over a valid/ready channel.
module parallel_latch_reader
  import parallel_latch_reader_pkg::*;
#(
  parameter int WAY  = 3,
  parameter int WIRE = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WAY*WIRE-1:0]        q,
  input  logic [WAY-1:0]             wr_en,
  input  logic                       out_ready,
  input  logic                       overrun_clr,
  output logic                       out_valid,
  output logic [WIRE-1:0]            out_data,
  output logic [idxWidth(WAY)-1:0]   out_way,
  output logic [WAY-1:0]             pending,
  output logic [WAY-1:0]             overrun
);

  localparam int IDXW = idxWidth(WAY);

  outState_e        state_q, state_d;
  logic [WAY-1:0]   wrQ_q;
  logic [WAY-1:0]   pending_q, pending_d;
  logic [WAY-1:0]   overrun_q, overrun_d;
  logic [IDXW-1:0]  rrPtr_q, rrPtr_d;
  logic [IDXW-1:0]  outWay_q, outWay_d;
  logic [WIRE-1:0]  outData_q, outData_d;

  logic [WAY-1:0]   closeEv;
  logic [WAY-1:0]   grantVec;
  logic [IDXW-1:0]  gntIdx;
  logic             gntAny;
  logic             outFree;
  logic             capture;
  logic [WIRE-1:0]  capWord;

  // A close is the enable falling: transparent last cycle, opaque now.
  assign closeEv = wrQ_q & ~wr_en;
  assign outFree = (state_q == ST_EMPTY) || out_ready;
  assign capture = outFree && gntAny;

  rr_pick #(
    .WAY(WAY)
  ) uPick (
    .req_i     (pending_q),
    .ptr_i     (rrPtr_q),
    .gnt_idx_o (gntIdx),
    .gnt_any_o (gntAny)
  );

  // Select the granted way's live latch word and flag the way being captured this cycle.
  always_comb begin
    capWord  = '0;
    grantVec = '0;
    for (int i = 0; i < WAY; i++) begin
      if (gntIdx == IDXW'(i)) begin
        capWord     = q[i*WIRE +: WIRE];
        grantVec[i] = capture;
      end
    end
  end

  // Next-state for the output register, pending/overrun flags and round-robin pointer.
  always_comb begin
    state_d   = state_q;
    outData_d = outData_q;
    outWay_d  = outWay_q;
    rrPtr_d   = rrPtr_q;
    pending_d = (pending_q | closeEv) & ~grantVec;
    overrun_d = (overrun_clr ? '0 : overrun_q) | (closeEv & pending_q & ~grantVec);
    if (capture) begin
      state_d   = ST_FULL;
      outData_d = capWord;
      outWay_d  = gntIdx;
      rrPtr_d   = (int'(gntIdx) == WAY - 1) ? '0 : gntIdx + IDXW'(1);
    end else if ((state_q == ST_FULL) && out_ready) begin
      state_d = ST_EMPTY;
    end
  end

  // State registers; reset drops any word held in the output register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_EMPTY;
      wrQ_q     <= '0;
      pending_q <= '0;
      overrun_q <= '0;
      rrPtr_q   <= '0;
      outWay_q  <= '0;
      outData_q <= '0;
    end else begin
      state_q   <= state_d;
      wrQ_q     <= wr_en;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      rrPtr_q   <= rrPtr_d;
      outWay_q  <= outWay_d;
      outData_q <= outData_d;
    end
  end

  assign out_valid = (state_q == ST_FULL);
  assign out_data  = outData_q;
  assign out_way   = outWay_q;
  assign pending   = pending_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_parallel_latch_reader.sv
// Self-checking bench for parallel_latch_reader (WAY=3, WIRE=8): expected
// beats are queued as closes are driven and popped as handshakes occur.
module tb_parallel_latch_reader;

  typedef struct {
    logic [1:0] way;
    logic [7:0] data;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] q;
  logic [2:0]  wr_en;
  logic        out_ready;
  logic        overrun_clr;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_way;
  logic [2:0]  pending;
  logic [2:0]  overrun;

  beat_t sb[$];
  beat_t expBeat;
  int    errors = 0;
  int    checks = 0;

  parallel_latch_reader #(
    .WAY(3),
    .WIRE(8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .q           (q),
    .wr_en       (wr_en),
    .out_ready   (out_ready),
    .overrun_clr (overrun_clr),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_way     (out_way),
    .pending     (pending),
    .overrun     (overrun)
  );

  // Free-running 10-time-unit clock.
  always #5 clk = ~clk;

  // Scoreboard: every accepted beat must match the oldest expected beat.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_beat: got way=%0d data=%h, required no beat", out_way, out_data);
      end else begin
        expBeat = sb.pop_front();
        if (out_way !== expBeat.way || out_data !== expBeat.data) begin
          errors++;
          $display("[TB] FAIL beat: got way=%0d data=%h, required way=%0d data=%h",
                   out_way, out_data, expBeat.way, expBeat.data);
        end
      end
    end
  end

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic waitDrain(input int maxCycles, output int used);
    used = 0;
    while (sb.size() != 0 && used <= maxCycles) begin
      tick(1);
      used++;
    end
  endtask

  task automatic resetPulse;
    rst_n = 1'b0; wr_en = 3'b000; out_ready = 1'b1; overrun_clr = 1'b0;
    tick(1);
    sb.delete();
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; wr_en = 3'b111; out_ready = 1'b1; overrun_clr = 1'b0; q = 24'h123456;
    tick(2);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b, required 0", out_valid); end
    checks++;
    if (out_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_data: got %h, required 00", out_data); end
    checks++;
    if (pending !== 3'b000) begin errors++; $display("[TB] FAIL reset_pending: got %b, required 000", pending); end
    checks++;
    if (overrun !== 3'b000) begin errors++; $display("[TB] FAIL reset_overrun: got %b, required 000", overrun); end
    rst_n = 1'b1;
    tick(3);
    checks++;
    if (out_valid !== 1'b0 || pending !== 3'b000) begin
      errors++;
      $display("[TB] FAIL no_close_when_high: got valid=%b pending=%b, required 0 000", out_valid, pending);
    end
    resetPulse();
  endtask

  task automatic test_single_close;
    int used;
    q = 24'h00A500; out_ready = 1'b1;
    sb.push_back('{2'd1, 8'hA5});
    wr_en = 3'b010; tick(1);
    wr_en = 3'b000; tick(1);
    checks++;
    if (pending !== 3'b010 || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_pending: got pending=%b valid=%b, required 010 0", pending, out_valid);
    end
    tick(1);
    checks++;
    if (out_valid !== 1'b1 || out_way !== 2'd1 || out_data !== 8'hA5) begin
      errors++;
      $display("[TB] FAIL single_beat: got valid=%b way=%0d data=%h, required 1 1 a5", out_valid, out_way, out_data);
    end
    tick(1);
    checks++;
    if (out_valid !== 1'b0 || pending !== 3'b000) begin
      errors++;
      $display("[TB] FAIL single_only_once: got valid=%b pending=%b, required 0 000", out_valid, pending);
    end
    waitDrain(4, used);
    checks++;
    if (sb.size() != 0) begin errors++; $display("[TB] FAIL single_drain: got %0d queued, required 0", sb.size()); end
  endtask

  task automatic test_back_to_back;
    int used;
    resetPulse();
    q = 24'hC2B1A0;
    sb.push_back('{2'd0, 8'hA0});
    sb.push_back('{2'd1, 8'hB1});
    sb.push_back('{2'd2, 8'hC2});
    wr_en = 3'b111; tick(1);
    wr_en = 3'b000; tick(1);
    checks++;
    if (pending !== 3'b111) begin errors++; $display("[TB] FAIL b2b_pending: got %b, required 111", pending); end
    waitDrain(10, used);
    checks++;
    if (used != 4) begin errors++; $display("[TB] FAIL b2b_rate: got %0d cycles, required 4", used); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_idle: got valid=%b, required 0", out_valid); end
    sb.push_back('{2'd0, 8'hA0});
    sb.push_back('{2'd2, 8'hC2});
    wr_en = 3'b101; tick(1);
    wr_en = 3'b000; tick(1);
    waitDrain(10, used);
    checks++;
    if (used != 3) begin errors++; $display("[TB] FAIL rr_pair_rate: got %0d cycles, required 3", used); end
    checks++;
    if (pending !== 3'b000) begin errors++; $display("[TB] FAIL rr_pair_pending: got %b, required 000", pending); end
  endtask

  task automatic test_overrun;
    int used;
    out_ready = 1'b0; q = 24'hC2B1A0;
    sb.push_back('{2'd0, 8'hA0});
    sb.push_back('{2'd2, 8'hC2});
    wr_en = 3'b001; tick(1);
    wr_en = 3'b000; tick(2);
    wr_en = 3'b100; tick(1);
    wr_en = 3'b000; tick(1);
    checks++;
    if (pending !== 3'b100 || overrun !== 3'b000) begin
      errors++;
      $display("[TB] FAIL ovr_first_close: got pending=%b overrun=%b, required 100 000", pending, overrun);
    end
    wr_en = 3'b100; tick(1);
    wr_en = 3'b000; tick(1);
    checks++;
    if (overrun !== 3'b100 || pending !== 3'b100) begin
      errors++;
      $display("[TB] FAIL ovr_set: got overrun=%b pending=%b, required 100 100", overrun, pending);
    end
    checks++;
    if (out_valid !== 1'b1 || out_way !== 2'd0 || out_data !== 8'hA0) begin
      errors++;
      $display("[TB] FAIL ovr_stall_stable: got valid=%b way=%0d data=%h, required 1 0 a0", out_valid, out_way, out_data);
    end
    overrun_clr = 1'b1; tick(1);
    overrun_clr = 1'b0;
    checks++;
    if (overrun !== 3'b000 || pending !== 3'b100) begin
      errors++;
      $display("[TB] FAIL ovr_clear: got overrun=%b pending=%b, required 000 100", overrun, pending);
    end
    out_ready = 1'b1;
    waitDrain(10, used);
    checks++;
    if (sb.size() != 0) begin errors++; $display("[TB] FAIL ovr_drain: got %0d queued, required 0", sb.size()); end
  endtask

  task automatic test_same_cycle_close;
    int used;
    out_ready = 1'b0; q = 24'hC2B155;
    sb.push_back('{2'd1, 8'hB1});
    sb.push_back('{2'd0, 8'h3C});
    wr_en = 3'b010; tick(1);
    wr_en = 3'b000; tick(2);
    wr_en = 3'b001; tick(1);
    wr_en = 3'b000; tick(1);
    wr_en = 3'b001; tick(1);
    checks++;
    if (pending !== 3'b001 || out_way !== 2'd1) begin
      errors++;
      $display("[TB] FAIL same_setup: got pending=%b way=%0d, required 001 1", pending, out_way);
    end
    q = 24'hC2B13C; wr_en = 3'b000; out_ready = 1'b1;
    tick(1);
    checks++;
    if (out_valid !== 1'b1 || out_way !== 2'd0 || out_data !== 8'h3C) begin
      errors++;
      $display("[TB] FAIL same_capture: got valid=%b way=%0d data=%h, required 1 0 3c", out_valid, out_way, out_data);
    end
    checks++;
    if (pending !== 3'b000 || overrun !== 3'b000) begin
      errors++;
      $display("[TB] FAIL same_flags: got pending=%b overrun=%b, required 000 000", pending, overrun);
    end
    waitDrain(10, used);
    checks++;
    if (sb.size() != 0) begin errors++; $display("[TB] FAIL same_drain: got %0d queued, required 0", sb.size()); end
  endtask

  task automatic test_reset_while_full;
    out_ready = 1'b0; q = 24'h778899;
    wr_en = 3'b001; tick(1);
    wr_en = 3'b000; tick(2);
    wr_en = 3'b110; tick(1);
    wr_en = 3'b000; tick(1);
    checks++;
    if (out_valid !== 1'b1 || pending !== 3'b110) begin
      errors++;
      $display("[TB] FAIL rstfull_setup: got valid=%b pending=%b, required 1 110", out_valid, pending);
    end
    rst_n = 1'b0; tick(1);
    sb.delete();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_way !== 2'd0) begin
      errors++;
      $display("[TB] FAIL rstfull_out: got valid=%b data=%h way=%0d, required 0 00 0", out_valid, out_data, out_way);
    end
    checks++;
    if (pending !== 3'b000 || overrun !== 3'b000) begin
      errors++;
      $display("[TB] FAIL rstfull_flags: got pending=%b overrun=%b, required 000 000", pending, overrun);
    end
    rst_n = 1'b1; out_ready = 1'b1;
    tick(4);
    checks++;
    if (out_valid !== 1'b0 || pending !== 3'b000) begin
      errors++;
      $display("[TB] FAIL rstfull_no_stale: got valid=%b pending=%b, required 0 000", out_valid, pending);
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    test_reset();
    test_single_close();
    test_back_to_back();
    test_overrun();
    test_same_cycle_close();
    test_reset_while_full();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
